// File: rtl/pll_reset_seq.sv
// -----------------------------------------------------------------------------
// pll_reset_seq
//   Reset sequencer sitting next to the rPLL on the reference clock domain.
//   It drives the PLL reset, synchronises the asynchronous PLL lock, and holds
//   the system reset until lock has been stable for a full settle window.
//   Lock loss in RUN (filtered) or a lock timeout in WAIT_LOCK sends the
//   sequencer back through a PLL reset pulse. Two saturating event counters
//   are exposed for the debug display.
//
// Ports
//   clk          in   reference clock (same net as PLL clkin)
//   reset        in   asynchronous, active-high reset
//   lock         in   PLL lock, asynchronous to clk
//   pll_reset    out  PLL reset request, active-high
//   sys_reset    out  system reset, active-high, low only in RUN
//   ready        out  high only in RUN
//   state        out  FSM state: 0=PLL_RST 1=WAIT_LOCK 2=SETTLE 3=RUN
//   retry_count  out  lock-timeout retries, saturating at 255
//   loss_count   out  lock losses seen in RUN, saturating at 255
//
// Interface note: there is no valid/ready handshake on this block. ready is a
// level status (high exactly while the FSM is in RUN); consumers sample it,
// they never acknowledge it.
// -----------------------------------------------------------------------------
module pll_reset_seq #(
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 270000,
  parameter int SETTLE_CYCLES  = 27000,
  parameter int LOSS_FILTER    = 4,
  parameter int CNT_W          = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lock,
  output logic       pll_reset,
  output logic       sys_reset,
  output logic       ready,
  output logic [1:0] state,
  output logic [7:0] retry_count,
  output logic [7:0] loss_count
);

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    SETTLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam int FILT_W = $clog2(LOSS_FILTER + 1);

  localparam logic [CNT_W-1:0]  L_PLL_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  L_TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  L_SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  L_TMR_ONE     = CNT_W'(1);
  localparam logic [FILT_W-1:0] L_FILT_LAST   = FILT_W'(LOSS_FILTER - 1);
  localparam logic [FILT_W-1:0] L_FILT_ONE    = FILT_W'(1);

  // Registers
  logic [SYNC_STAGES-1:0] r_sync;
  state_t                 r_state;
  logic [CNT_W-1:0]       r_timer;
  logic [FILT_W-1:0]      r_filt;
  logic [7:0]             r_retry;
  logic [7:0]             r_loss;
  logic                   r_pll_reset;
  logic                   r_sys_reset;
  logic                   r_ready;

  // Next-state wires
  logic                   w_lock_s;
  state_t                 w_state_nx;
  logic [CNT_W-1:0]       w_timer_nx;
  logic [FILT_W-1:0]      w_filt_nx;
  logic [7:0]             w_retry_nx;
  logic [7:0]             w_loss_nx;

  // ---------------------------------------------------------------------------
  // Lock synchroniser. The FSM only ever looks at the last stage.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], lock};
    end
  end

  assign w_lock_s = r_sync[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // FSM state register, timers and counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= PLL_RST;
      r_timer <= '0;
      r_filt  <= '0;
      r_retry <= '0;
      r_loss  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_timer <= w_timer_nx;
      r_filt  <= w_filt_nx;
      r_retry <= w_retry_nx;
      r_loss  <= w_loss_nx;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nx = r_state;
    w_timer_nx = r_timer;
    w_filt_nx  = '0;
    w_retry_nx = r_retry;
    w_loss_nx  = r_loss;

    unique case (r_state)
      PLL_RST: begin
        if (r_timer == L_PLL_LAST) begin
          w_state_nx = WAIT_LOCK;
          w_timer_nx = '0;
        end else begin
          w_timer_nx = r_timer + L_TMR_ONE;
        end
      end

      WAIT_LOCK: begin
        if (w_lock_s) begin
          w_state_nx = SETTLE;
          w_timer_nx = '0;
        end else if (r_timer == L_TIMEOUT_LAST) begin
          w_state_nx = PLL_RST;
          w_timer_nx = '0;
          w_retry_nx = (r_retry == 8'hFF) ? r_retry : r_retry + 8'd1;
        end else begin
          w_timer_nx = r_timer + L_TMR_ONE;
        end
      end

      SETTLE: begin
        // Any unlocked cycle restarts the whole lock/settle sequence; the
        // settle window is never resumed part-way.
        if (!w_lock_s) begin
          w_state_nx = WAIT_LOCK;
          w_timer_nx = '0;
        end else if (r_timer == L_SETTLE_LAST) begin
          w_state_nx = RUN;
          w_timer_nx = '0;
        end else begin
          w_timer_nx = r_timer + L_TMR_ONE;
        end
      end

      RUN: begin
        // Filter counts consecutive unlocked cycles; a single locked cycle
        // clears it, so short glitches never reach the outputs.
        w_timer_nx = '0;
        if (w_lock_s) begin
          w_filt_nx = '0;
        end else if (r_filt == L_FILT_LAST) begin
          w_state_nx = PLL_RST;
          w_filt_nx  = '0;
          w_loss_nx  = (r_loss == 8'hFF) ? r_loss : r_loss + 8'd1;
        end else begin
          w_filt_nx = r_filt + L_FILT_ONE;
        end
      end

      default: begin
        w_state_nx = PLL_RST;
        w_timer_nx = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered outputs decoded from the next state, so they switch on the same
  // edge as the state register.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pll_reset <= 1'b1;
      r_sys_reset <= 1'b1;
      r_ready     <= 1'b0;
    end else begin
      r_pll_reset <= (w_state_nx == PLL_RST);
      r_sys_reset <= (w_state_nx != RUN);
      r_ready     <= (w_state_nx == RUN);
    end
  end

  assign pll_reset   = r_pll_reset;
  assign sys_reset   = r_sys_reset;
  assign ready       = r_ready;
  assign state       = r_state;
  assign retry_count = r_retry;
  assign loss_count  = r_loss;

endmodule
